// File: rtl/fll_cfg_responder.sv
`default_nettype none
// ============================================================================
// Module  : fll_cfg_responder
// Brief   : FLL_BUS target-side register model with a lock-sequence model.
//           Optional macro FLL_CFG_LOCK_IRQ_EN adds irq_o (lock change pulse).
// Revision: 1.0 - initial release
// ============================================================================
module fll_cfg_responder #(
  parameter int unsigned ACK_LATENCY = 2,
  parameter int unsigned LOCK_CYCLES = 64,
  parameter logic [31:0] CFG1_RST    = 32'h0000_05F5,
  parameter logic [31:0] CFG2_RST    = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [1:0]  addr_i,
  input  logic        web_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        lock_o
`ifdef FLL_CFG_LOCK_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam logic [3:0]  LAT_INIT   = 4'(ACK_LATENCY - 1);
  localparam logic [15:0] LOCK_INIT  = 16'(LOCK_CYCLES);
  localparam logic [31:0] INTEG_MASK = 32'h03FF_FFC0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] cfg1_q, cfg1_d;
  logic [31:0] cfg2_q, cfg2_d;
  logic [31:0] integ_q, integ_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] lcnt_q, lcnt_d;
  logic        lock_q, lock_d;
  logic        access;
  logic        wr_cfg1;
  logic [31:0] rd_mux;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (ACK_LATENCY == 1) begin
            state_d = S_ACK;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            lat_d   = LAT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Request withdrawn before grant: abandon without touching registers.
        if (!req_i) begin
          state_d = S_IDLE;
        end else if (lat_q <= 4'd1) begin
          state_d = S_ACK;
          access  = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_ACK: begin
        if (!req_i) state_d = S_RELEASE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    case (addr_i)
      2'd0:    rd_mux = {15'h0, lock_q, (lock_q ? cfg1_q[15:0] : 16'h0)};
      2'd1:    rd_mux = cfg1_q;
      2'd2:    rd_mux = cfg2_q;
      default: rd_mux = integ_q;
    endcase
  end

  always_comb begin
    cfg1_d  = cfg1_q;
    cfg2_d  = cfg2_q;
    integ_d = integ_q;
    rdata_d = rdata_q;
    wr_cfg1 = 1'b0;
    if (access && !web_i) begin
      case (addr_i)
        2'd1: begin
          cfg1_d  = wdata_i;
          wr_cfg1 = 1'b1;
        end
        2'd2:    cfg2_d  = wdata_i;
        2'd3:    integ_d = wdata_i & INTEG_MASK;
        default: ;
      endcase
    end
    if (access && web_i) rdata_d = rd_mux;
  end

  // Any committed CONFIG1 write restarts the lock sequence, even with an unchanged value.
  always_comb begin
    if (wr_cfg1) begin
      lcnt_d = LOCK_INIT;
      lock_d = 1'b0;
    end else begin
      lcnt_d = (lcnt_q != 16'h0) ? lcnt_q - 16'h1 : lcnt_q;
      lock_d = (lcnt_q == 16'h0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lat_q   <= 4'h0;
      cfg1_q  <= CFG1_RST;
      cfg2_q  <= CFG2_RST;
      integ_q <= 32'h0;
      rdata_q <= 32'h0;
      lcnt_q  <= LOCK_INIT;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cfg1_q  <= cfg1_d;
      cfg2_q  <= cfg2_d;
      integ_q <= integ_d;
      rdata_q <= rdata_d;
      lcnt_q  <= lcnt_d;
      lock_q  <= lock_d;
    end
  end

  assign ack_o   = (state_q == S_ACK);
  assign rdata_o = rdata_q;
  assign lock_o  = lock_q;

`ifdef FLL_CFG_LOCK_IRQ_EN
  logic irq_q;

  // Lock only rises via the counter and only falls via a CONFIG1 write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= lock_d ^ lock_q;
  end

  assign irq_o = irq_q;
`endif

endmodule
`default_nettype wire
